tt_um_microtile_pulsegen: RTL

TT_UM_MICROTILE_PULSEGEN -- requirements
Module: tt_um_microtile_pulsegen

---
 rtl/tt_um_microtile_pulsegen.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/tt_um_microtile_pulsegen.sv
// Start/stop pulse-pair generator: a go edge launches a start pulse, then a stop pulse D cycles later.
// Optional burst mode (N pairs separated by gaps) is compiled only with MICROTILE_PULSEGEN_BURST_EN.
module tt_um_microtile_pulsegen (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    typedef enum logic [2:0] {StIdle, StStart, StDelay, StStop, StGap} state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] dly_q, dly_d;
    logic [2:0] gap_q, gap_d;
    logic [4:0] pairs_q, pairs_d;
    logic       go_q;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       go_edge;
    logic       stop_seen;
    logic       last_pair;
    logic [4:0] pairs_dec;
    logic [4:0] launch_pairs;
    logic       unused_ok;

    assign go_edge   = uio_in[0] & ~go_q;
    assign last_pair = (pairs_q <= 5'd1);
    assign pairs_dec = (pairs_q == 5'd0) ? 5'd0 : pairs_q - 5'd1;

`ifdef MICROTILE_PULSEGEN_BURST_EN
    // Burst count of 0 stands for 16 pairs.
    assign launch_pairs = !uio_in[1] ? 5'd1 :
                          (uio_in[7:4] == 4'd0) ? 5'd16 : {1'b0, uio_in[7:4]};
`else
    assign launch_pairs = 5'd0;
`endif

    assign unused_ok = &{1'b0, uio_in[7:1]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dly_d     = dly_q;
        gap_d     = gap_q;
        pairs_d   = pairs_q;
        start_d   = 1'b0;
        stop_d    = 1'b0;
        done_d    = 1'b0;
        stop_seen = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (go_edge) begin
                    state_d = StStart;
                    dly_d   = ui_in;
                    cnt_d   = ui_in;
                    pairs_d = launch_pairs;
                    start_d = 1'b1;
                    stop_d  = (ui_in == 8'd0);
                end
            end
            StStart: begin
                // The counter still holds D here; D=0 means this cycle was also the stop.
                if (cnt_q == 8'd0) begin
                    stop_seen = 1'b1;
                end else if (cnt_q == 8'd1) begin
                    state_d = StStop;
                    stop_d  = 1'b1;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = StDelay;
                    cnt_d   = cnt_q - 8'd1;
                end
            end
            StDelay: begin
                if (cnt_q == 8'd1) begin
                    state_d = StStop;
                    stop_d  = 1'b1;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StStop: begin
                stop_seen = 1'b1;
            end
            StGap: begin
                if (gap_q == 3'd0) begin
                    state_d = StStart;
                    cnt_d   = dly_q;
                    start_d = 1'b1;
                    stop_d  = (dly_q == 8'd0);
                end else begin
                    gap_d = gap_q - 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (stop_seen) begin
            pairs_d = pairs_dec;
            if (last_pair) begin
                state_d = StIdle;
                done_d  = 1'b1;
            end else begin
                state_d = StGap;
                gap_d   = 3'd4;
            end
        end

        // Disable aborts silently: no done, count cleared.
        if (!ena) begin
            state_d = StIdle;
            cnt_d   = 8'd0;
            gap_d   = 3'd0;
            pairs_d = 5'd0;
            start_d = 1'b0;
            stop_d  = 1'b0;
            done_d  = 1'b0;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            dly_q   <= 8'd0;
            gap_q   <= 3'd0;
            pairs_q <= 5'd0;
            go_q    <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dly_q   <= dly_d;
            gap_q   <= gap_d;
            pairs_q <= pairs_d;
            go_q    <= uio_in[0];
            start_q <= start_d;
            stop_q  <= stop_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign uo_out  = {pairs_q[3:0], done_q, busy_q, stop_q, start_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule
